// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 16;

endpackage

// File: rtl/tx_bit_timer.sv
// rtl/tx_bit_timer.sv - bit-period counter, pulses bit_done on the last clock of each bit
module tx_bit_timer
    import uart_pkg::*;
#(
    parameter int PULSES_BIT = 28
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PULSES_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_done = enable && (cnt_q == LAST);

    // Count through one bit period, wrapping to zero on the bit boundary
    always_comb begin
        cnt_d = cnt_q;
        if (clear || bit_done) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tx.sv
// rtl/tx.sv - UART transmitter with one-byte holding register; UART_TX_STOP2_EN selects two stop bits
module tx
    import uart_pkg::*;
#(
    parameter int PULSES_BIT = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       data_Tx,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       data_tx_q, data_tx_d;

    logic       timer_clear;
    logic       timer_en;
    logic       bit_done;
    logic       stop_last;

    tx_bit_timer #(
        .PULSES_BIT(PULSES_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .bit_done(bit_done)
    );

`ifdef UART_TX_STOP2_EN
    logic stop_second_q, stop_second_d;

    // Toggles on each stop-bit boundary so the frame ends on the second one
    always_comb begin
        stop_second_d = stop_second_q;
        if (state_q == STOP && bit_done) begin
            stop_second_d = !stop_second_q;
        end
    end

    // Second-stop-bit flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_second_q <= 1'b0;
        end else begin
            stop_second_q <= stop_second_d;
        end
    end

    assign stop_last = stop_second_q;
`else
    assign stop_last = 1'b1;
`endif

    assign ready   = !hold_full_q;
    assign data_Tx = data_tx_q;
    assign busy    = (state_q != IDLE);

    // Handshake, frame sequencing and next line level
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        // ready is low whenever hold is full, so this never collides with a load
        if (valid && !hold_full_q) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = '0;
                    state_d     = START;
                end
            end
            START: begin
                timer_en = 1'b1;
                if (bit_done) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                timer_en = 1'b1;
                if (bit_done) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                timer_en = 1'b1;
                if (bit_done && stop_last) begin
                    // Chain straight into the next start bit when a byte is waiting
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        bit_cnt_d   = '0;
                        state_d     = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   data_tx_d = 1'b0;
            DATA:    data_tx_d = shift_d[bit_cnt_d];
            default: data_tx_d = 1'b1;
        endcase
    end

    // State, datapath and registered line output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            data_tx_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            data_tx_q   <= data_tx_d;
        end
    end

endmodule

// File: doc/tx.md
# tx

UART transmitter: serialises one byte per frame onto a single idle-high line at PULSES_BIT clocks per bit, LSB first. It is the transmit end of the GPIO serial link and pairs with the team's receiver. It sits between a byte-producing core (valid/ready source) and the FPGA output pin. A one-entry holding register lets the source queue the next byte while the current frame shifts out, so frames go out back-to-back.

## Interface
- PULSES_BIT, 28, clocks per bit period; legal range 2..65535 (16-bit counter)
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  asynchronous, active-low reset
- data_in  input  8  byte to send; sampled on the accepting edge
- valid  input  1  source has a byte on data_in
- ready  output  1  holding register empty; byte accepted on any posedge with valid && ready
- data_Tx  output  1  serial line, registered, idle high
- busy  output  1  high while a frame is on the line (state != IDLE)

## Operation
- Reset values: data_Tx=1, ready=1, busy=0; state IDLE, counters 0, hold empty.
- Handshake: ready = !hold_full (from a register, no combinational path from valid). On valid && ready: hold <= data_in, hold_full <= 1. Source holds data_in stable while valid && !ready. valid while ready=0 has no effect.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: data_Tx=1. If hold_full: shift <= hold, hold_full <= 0, bit_cnt <= 0, cnt <= 0, -> START.
  - START: data_Tx=0 for PULSES_BIT cycles, then -> DATA.
  - DATA: data_Tx=shift[bit_cnt], PULSES_BIT cycles per bit; bit_cnt 0..7; after bit 7 -> STOP.
  - STOP: data_Tx=1 for PULSES_BIT cycles (x2 with UART_TX_STOP2_EN). At end: if hold_full, load as in IDLE and -> START on the same edge (no idle gap); else -> IDLE.
- cnt counts 0..PULSES_BIT-1; wraps to 0 at each bit boundary. bit_cnt wraps 7->0 on entering STOP.
- A load and an acceptance never coincide: ready=0 whenever hold_full=1, so hold is only written when empty.
- Reset asserted mid-frame: data_Tx goes high asynchronously, frame is truncated, hold contents discarded, ready=1.

## Timing
- Accept at edge E: hold_full=1 after E, ready=0 after E.
- If IDLE: load at E+1; data_Tx falls after E+1; ready returns to 1 after E+1.
- Frame length: exactly 10*PULSES_BIT cycles (11*PULSES_BIT with stop2) from data_Tx fall to the next possible fall.
- Back-to-back: next start bit begins on the edge that ends the stop period; busy stays 1 throughout.
- busy falls on the edge that ends the stop period when hold is empty.

## Configuration
- UART_TX_STOP2_EN defined: stop period is 2*PULSES_BIT cycles (two stop bits), frame 11*PULSES_BIT.
- Undefined (default): one stop bit, frame 10*PULSES_BIT. Use the default when the link partner is the team's receiver at its default configuration.

## Structure
- Shared package uart_pkg: tx state enum (IDLE/START/DATA/STOP), DATA_BITS=8, counter width constant CNT_W=16.
- One sub-module: tx_bit_timer (cnt register, clear/enable inputs, bit_done pulse at cnt==PULSES_BIT-1). Remaining FSM, shift and hold logic in tx.

## Test plan
- Single byte 0xA5, PULSES_BIT=28: data_Tx low 28 cycles, then 1,0,1,0,0,1,0,1 each 28 cycles, then high 28 cycles; busy high 280 cycles; ready back to 1 one cycle after acceptance.
- Back-to-back 0x00 then 0xFF, valid held high: second byte accepted while first shifts; second start bit immediately follows first stop bit; line low 9*28 cycles, high 1*28, low 1*28, high 9*28.
- Loopback into the team's receiver with bytes 0x00, 0x55, 0xAA, 0xFF, 0x3C: receiver outputs each byte once with one valid pulse, in order.
- valid asserted while ready=0 with a changing data_in: no byte lost or duplicated; only bytes presented with ready=1 appear on the line.
- rst_n pulsed low mid-bit 3 of 0x5A with a byte in hold: data_Tx=1, busy=0, ready=1 immediately; no further frame after release until new valid.
- UART_TX_STOP2_EN build, byte 0x81: stop period 56 cycles, frame 308 cycles, back-to-back spacing 308 cycles.
